// File: rtl/key_debounce.sv
// key_debounce: multi-key synchronizer, debouncer and press/release/long-press event generator.
// Ports: sys_clk, rst_n (async, active-low), key_in (raw, 0=pressed) -> key_level, key_press, key_release, key_long.
module key_debounce #(
   parameter int CLK_FREQ    = 50_000_000,
   parameter int KEY_NUM     = 4,
   parameter int DEBOUNCE_MS = 20,
   parameter int LONG_MS     = 1000
) (
   input  logic               sys_clk,
   input  logic               rst_n,
   input  logic [KEY_NUM-1:0] key_in,
   output logic [KEY_NUM-1:0] key_level,
   output logic [KEY_NUM-1:0] key_press,
   output logic [KEY_NUM-1:0] key_release,
   output logic [KEY_NUM-1:0] key_long
);

   localparam int DB_CYC   = CLK_FREQ / 1000 * DEBOUNCE_MS;
   localparam int LONG_CYC = CLK_FREQ / 1000 * LONG_MS;
   localparam int DB_W     = $clog2(DB_CYC);
   localparam int LG_W     = $clog2(LONG_CYC);

   localparam logic [DB_W-1:0] DB_MAX = DB_W'(DB_CYC - 1);
   localparam logic [LG_W-1:0] LG_MAX = LG_W'(LONG_CYC - 1);
   localparam logic [LG_W-1:0] LG_PRE = LG_W'(LONG_CYC - 2);

   typedef enum logic [1:0] {
      IDLE,
      PRESS_WAIT,
      PRESSED,
      RELEASE_WAIT
   } state_t;

   for (genvar k = 0; k < KEY_NUM; k++) begin : g_key
      logic            r_sync1;
      logic            r_sync2;
      state_t          r_state;
      state_t          w_state_nxt;
      logic [DB_W-1:0] r_db_cnt;
      logic [DB_W-1:0] w_db_nxt;
      logic [LG_W-1:0] r_long_cnt;
      logic [LG_W-1:0] w_long_cnt_nxt;
      logic            r_level;
      logic            w_level_nxt;
      logic            r_press;
      logic            w_press_nxt;
      logic            r_release;
      logic            w_release_nxt;
      logic            r_long;
      logic            w_long_nxt;

      // State register: synchronizer, FSM, counters and registered outputs
      always_ff @(posedge sys_clk or negedge rst_n) begin
         if (!rst_n) begin
            r_sync1    <= 1'b1;
            r_sync2    <= 1'b1;
            r_state    <= IDLE;
            r_db_cnt   <= '0;
            r_long_cnt <= '0;
            r_level    <= 1'b0;
            r_press    <= 1'b0;
            r_release  <= 1'b0;
            r_long     <= 1'b0;
         end else begin
            r_sync1    <= key_in[k];
            r_sync2    <= r_sync1;
            r_state    <= w_state_nxt;
            r_db_cnt   <= w_db_nxt;
            r_long_cnt <= w_long_cnt_nxt;
            r_level    <= w_level_nxt;
            r_press    <= w_press_nxt;
            r_release  <= w_release_nxt;
            r_long     <= w_long_nxt;
         end
      end

      // Next-state logic; r_sync2 == 0 means the key is pressed
      always_comb begin
         w_state_nxt = r_state;
         unique case (r_state)
            IDLE: begin
               if (!r_sync2) w_state_nxt = PRESS_WAIT;
            end
            PRESS_WAIT: begin
               if (r_sync2)                w_state_nxt = IDLE;
               else if (r_db_cnt == DB_MAX) w_state_nxt = PRESSED;
            end
            PRESSED: begin
               if (r_sync2) w_state_nxt = RELEASE_WAIT;
            end
            RELEASE_WAIT: begin
               if (!r_sync2)               w_state_nxt = PRESSED;
               else if (r_db_cnt == DB_MAX) w_state_nxt = IDLE;
            end
         endcase
      end

      // Counter and output next values
      always_comb begin
         w_db_nxt       = r_db_cnt;
         w_long_cnt_nxt = r_long_cnt;
         w_level_nxt    = r_level;
         w_press_nxt    = 1'b0;
         w_release_nxt  = 1'b0;
         w_long_nxt     = 1'b0;
         unique case (r_state)
            IDLE: begin
               w_db_nxt = '0;
            end
            PRESS_WAIT: begin
               if (!r_sync2) begin
                  if (r_db_cnt == DB_MAX) begin
                     w_level_nxt    = 1'b1;
                     w_press_nxt    = 1'b1;
                     w_long_cnt_nxt = '0;
                  end else begin
                     w_db_nxt = r_db_cnt + DB_W'(1);
                  end
               end
            end
            PRESSED: begin
               w_db_nxt = '0;
               // Saturating hold timer; the pulse fires only on the
               // step into saturation, so it cannot repeat.
               if (r_long_cnt != LG_MAX) begin
                  w_long_cnt_nxt = r_long_cnt + LG_W'(1);
                  if (r_long_cnt == LG_PRE) w_long_nxt = 1'b1;
               end
            end
            RELEASE_WAIT: begin
               if (r_sync2) begin
                  if (r_db_cnt == DB_MAX) begin
                     w_level_nxt   = 1'b0;
                     w_release_nxt = 1'b1;
                  end else begin
                     w_db_nxt = r_db_cnt + DB_W'(1);
                  end
               end
            end
         endcase
      end

      assign key_level[k]   = r_level;
      assign key_press[k]   = r_press;
      assign key_release[k] = r_release;
      assign key_long[k]    = r_long;
   end

endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: table vectors, directed corner sequences and
// randomized key activity against a run-length reference model.
module tb_key_debounce;

   localparam int CLK_FREQ    = 10_000;
   localparam int KEY_NUM     = 4;
   localparam int DEBOUNCE_MS = 2;
   localparam int LONG_MS     = 10;
   localparam int DB_CYC      = 20;
   localparam int LONG_CYC    = 100;

   logic               sys_clk = 1'b0;
   logic               rst_n   = 1'b0;
   logic [KEY_NUM-1:0] key_in  = '1;
   logic [KEY_NUM-1:0] key_level;
   logic [KEY_NUM-1:0] key_press;
   logic [KEY_NUM-1:0] key_release;
   logic [KEY_NUM-1:0] key_long;

   always #5 sys_clk = ~sys_clk;

   key_debounce #(
      .CLK_FREQ   (CLK_FREQ),
      .KEY_NUM    (KEY_NUM),
      .DEBOUNCE_MS(DEBOUNCE_MS),
      .LONG_MS    (LONG_MS)
   ) dut (
      .sys_clk    (sys_clk),
      .rst_n      (rst_n),
      .key_in     (key_in),
      .key_level  (key_level),
      .key_press  (key_press),
      .key_release(key_release),
      .key_long   (key_long)
   );

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;

   // Reference model: a key's accepted level flips once the synchronized
   // pin has disagreed with it for DB_CYC+1 consecutive edges.
   bit   m_d1   [KEY_NUM];
   bit   m_d2   [KEY_NUM];
   bit   m_lvl  [KEY_NUM];
   int   m_run  [KEY_NUM];
   int   m_hold [KEY_NUM];
   logic [KEY_NUM-1:0] m_level, m_press, m_rel, m_long;

   int cnt_p [KEY_NUM];
   int cnt_r [KEY_NUM];
   int cnt_l [KEY_NUM];
   int last_p[KEY_NUM];
   int last_l[KEY_NUM];

   typedef struct {
      logic [3:0]  keys;
      int          n;
      logic [15:0] exp;
   } vec_t;

   function automatic logic [15:0] dut_vec();
      return {key_long, key_release, key_press, key_level};
   endfunction

   function automatic logic [15:0] m_vec();
      return {m_long, m_rel, m_press, m_level};
   endfunction

   function automatic void m_reset();
      for (int k = 0; k < KEY_NUM; k++) begin
         m_d1[k] = 1'b1; m_d2[k] = 1'b1; m_lvl[k] = 1'b0;
         m_run[k] = 0; m_hold[k] = 0;
      end
      m_level = '0; m_press = '0; m_rel = '0; m_long = '0;
   endfunction

   function automatic void m_edge();
      bit seen_pressed;
      bit in_hold;
      m_press = '0; m_rel = '0; m_long = '0;
      for (int k = 0; k < KEY_NUM; k++) begin
         seen_pressed = !m_d2[k];
         m_d2[k] = m_d1[k];
         m_d1[k] = key_in[k];
         in_hold = m_lvl[k] && (m_run[k] == 0);
         if (in_hold && m_hold[k] < LONG_CYC - 1) begin
            m_hold[k]++;
            if (m_hold[k] == LONG_CYC - 1) m_long[k] = 1'b1;
         end
         if (seen_pressed != m_lvl[k]) begin
            m_run[k]++;
            if (m_run[k] == DB_CYC + 1) begin
               m_lvl[k] = seen_pressed;
               m_run[k] = 0;
               if (seen_pressed) begin
                  m_press[k] = 1'b1;
                  m_hold[k] = 0;
               end else begin
                  m_rel[k] = 1'b1;
               end
            end
         end else begin
            m_run[k] = 0;
         end
         m_level[k] = m_lvl[k];
      end
   endfunction

   task automatic check(input string nm, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, got, exp);
   endtask

   task automatic step();
      @(posedge sys_clk);
      cyc++;
      if (rst_n) m_edge();
      else       m_reset();
      #1;
      check("model", int'(dut_vec()), int'(m_vec()));
   endtask

   task automatic clr_cnt();
      for (int k = 0; k < KEY_NUM; k++) begin
         cnt_p[k] = 0; cnt_r[k] = 0; cnt_l[k] = 0;
         last_p[k] = -1; last_l[k] = -1;
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         step();
         for (int k = 0; k < KEY_NUM; k++) begin
            if (key_press[k])   begin cnt_p[k]++; last_p[k] = cyc; end
            if (key_release[k]) cnt_r[k]++;
            if (key_long[k])    begin cnt_l[k]++; last_l[k] = cyc; end
         end
      end
   endtask

   // Called just after a step (edge+1): asserts reset between edges.
   task automatic async_rst();
      #2;
      rst_n = 1'b0;
      #1;
      m_reset();
      check("async_clear", int'(dut_vec()), 0);
   endtask

   vec_t tbl[8];
   int   dwell[KEY_NUM];
   int   k0;
   logic [15:0] acc;

   initial begin
      tbl[0] = '{4'hF,  5, 16'h0000};
      tbl[1] = '{4'hE, 22, 16'h0000};
      tbl[2] = '{4'hE,  1, 16'h0011};
      tbl[3] = '{4'hE,  1, 16'h0001};
      tbl[4] = '{4'hE, 36, 16'h0001};
      tbl[5] = '{4'hF, 22, 16'h0001};
      tbl[6] = '{4'hF,  1, 16'h0100};
      tbl[7] = '{4'hF,  1, 16'h0000};

      m_reset();
      clr_cnt();
      #1;
      check("reset_state", int'(dut_vec()), 0);
      for (int i = 0; i < 3; i++) step();
      rst_n = 1'b1;

      // Idle, all keys released
      acc = '0;
      for (int i = 0; i < 200; i++) begin
         step();
         acc |= dut_vec();
      end
      check("idle_quiet", int'(acc), 0);

      // Clean press/release on key 0
      clr_cnt();
      for (int i = 0; i < 8; i++) begin
         key_in = tbl[i].keys;
         run(tbl[i].n);
         check($sformatf("tbl%0d", i), int'(dut_vec()), int'(tbl[i].exp));
      end
      check("clean_press_cnt", cnt_p[0], 1);
      check("clean_rel_cnt", cnt_r[0], 1);
      check("clean_no_long", cnt_l[0], 0);

      // Bounce on key 1
      clr_cnt();
      for (int i = 0; i < 5; i++) begin
         key_in[1] = 1'b0; run(8);
         key_in[1] = 1'b1; run(3);
      end
      key_in[1] = 1'b0;
      k0 = cyc + 1;
      run(40);
      check("bounce_press_cnt", cnt_p[1], 1);
      check("bounce_press_lat", last_p[1] - k0, 22);
      check("bounce_no_rel", cnt_r[1], 0);
      key_in[1] = 1'b1;
      run(30);
      check("bounce_rel_cnt", cnt_r[1], 1);

      // Long press on key 2
      clr_cnt();
      key_in[2] = 1'b0;
      run(300);
      check("long_press_cnt", cnt_p[2], 1);
      check("long_cnt", cnt_l[2], 1);
      check("long_lat", last_l[2] - last_p[2], LONG_CYC - 1);
      key_in[2] = 1'b1;
      run(30);
      check("long_rel_cnt", cnt_r[2], 1);
      check("long_no_repeat", cnt_l[2], 1);

      // Simultaneous presses on keys 0 and 3
      clr_cnt();
      key_in[0] = 1'b0;
      key_in[3] = 1'b0;
      run(40);
      check("simul_cnt0", cnt_p[0], 1);
      check("simul_cnt3", cnt_p[3], 1);
      check("simul_same_cyc", last_p[0], last_p[3]);
      key_in = '1;
      run(30);

      // Reset pulse while key 1 is held
      clr_cnt();
      key_in[1] = 1'b0;
      run(23);
      check("rst_pre_press", cnt_p[1], 1);
      run(10);
      check("rst_pre_level", int'(key_level[1]), 1);
      clr_cnt();
      async_rst();
      run(3);
      rst_n = 1'b1;
      k0 = cyc + 1;
      run(30);
      check("rst_no_release", cnt_r[1], 0);
      check("rst_repress_cnt", cnt_p[1], 1);
      check("rst_repress_lat", last_p[1] - k0, 22);
      key_in[1] = 1'b1;
      run(30);

      // Randomized activity with bounces, long holds and a reset
      for (int k = 0; k < KEY_NUM; k++)
         dwell[k] = int'($urandom_range(1, 60));
      for (int c = 0; c < 4000; c++) begin
         if (c == 2000) begin
            async_rst();
            run(2);
            rst_n = 1'b1;
         end
         for (int k = 0; k < KEY_NUM; k++) begin
            if (dwell[k] == 0) begin
               key_in[k] = ~key_in[k];
               if ($urandom_range(0, 1) == 1)
                  dwell[k] = int'($urandom_range(1, 12));
               else
                  dwell[k] = int'($urandom_range(15, 150));
            end else begin
               dwell[k]--;
            end
         end
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/key_debounce.md
# key_debounce

Multi-key debouncer and event generator for the board's active-low push-buttons. It is the input-side companion of the LED pattern generators: it turns raw, bouncing key pins into clean one-cycle press, release and long-press events for the mode and pattern controllers. Each key gets a two-flop synchronizer, a debounce state machine, and a long-press timer.

## Interface
- `CLK_FREQ`, default 50_000_000: sys_clk frequency in Hz.
- `KEY_NUM`, default 4: number of keys, 1..8.
- `DEBOUNCE_MS`, default 20: stable time required to accept a level change.
- `LONG_MS`, default 1000: held time before the long-press event.
- Derived constants:
  - DB_CYC = CLK_FREQ/1000*DEBOUNCE_MS, required ≥ 2.
  - LONG_CYC = CLK_FREQ/1000*LONG_MS, required > DB_CYC.
  - Counter widths are $clog2 of each constant.

Ports:
- `sys_clk`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `key_in`  in  KEY_NUM  raw key pins, asynchronous to sys_clk, 0 = pressed.
- `key_level`  out  KEY_NUM  debounced state, 1 = pressed.
- `key_press`  out  KEY_NUM  one-cycle pulse on an accepted press.
- `key_release`  out  KEY_NUM  one-cycle pulse on an accepted release.
- `key_long`  out  KEY_NUM  one-cycle pulse once per press, when the hold reaches LONG_CYC.

## Operation
- Per key, fully independent. In the rules below, `s` = second synchronizer stage; s = 0 means pressed.
- Reset (asynchronous assert, release takes effect on the next edge):
  - both synchronizer stages = 1;
  - FSM = IDLE;
  - all counters = 0;
  - all outputs = 0.
- The FSM has four states:
  - **IDLE** (released and stable): if s = 0, go to PRESS_WAIT with db_cnt = 0.
  - **PRESS_WAIT**:
    - if s = 1, go to IDLE; no event.
    - else if db_cnt == DB_CYC-1, go to PRESSED: set key_level = 1, pulse key_press, clear long_cnt.
    - else increment db_cnt.
  - **PRESSED**:
    - long_cnt increments and saturates at LONG_CYC-1.
    - On the edge where long_cnt reaches LONG_CYC-1, pulse key_long. This happens exactly once per press, with no auto-repeat.
    - If s = 1, go to RELEASE_WAIT with db_cnt = 0; long_cnt holds its value.
  - **RELEASE_WAIT**:
    - if s = 0, go back to PRESSED. A bounce; no event; long_cnt keeps its value and does not restart.
    - else if db_cnt == DB_CYC-1, go to IDLE: set key_level = 0, pulse key_release.
    - else increment db_cnt. long_cnt does not advance here.
- All outputs are registered, with no combinational path from key_in.
- Pulses are exactly 1 cycle wide.
- key_press and key_release for the same key are never asserted together.
- key_long is always preceded by key_press in the same press and followed by key_release.
- Simultaneous activity on different keys yields independent, possibly same-cycle events.

## Timing
- Synchronizer latency is 2 cycles.
- Press latency: if key_in falls before edge k and stays low, then:
  - s = 0 after edge k+1;
  - PRESS_WAIT is entered at edge k+2;
  - key_press and key_level rise at edge k+DB_CYC+2.
- Release latency is symmetric: key_release is high for the cycle after edge k+DB_CYC+2, and key_level falls at that same edge.
- A press, or release, of stable duration ≤ DB_CYC-1 synchronized cycles produces no event and no change on key_level.
- key_long rises LONG_CYC-1 cycles after key_press rises, counting only cycles spent in PRESSED.
- Reset asserted mid-operation:
  - all outputs clear immediately, and any pulse in progress is truncated;
  - no release event is generated for a key that was held.
- Reset released while a key is held: the key is treated as a fresh press and gets a full debounce, then key_press.

## Test plan
All scenarios use CLK_FREQ=10_000, DEBOUNCE_MS=2 (DB_CYC=20), LONG_MS=10 (LONG_CYC=100), KEY_NUM=4.

1. Reset, with all key_in = 1: all outputs are 0 for 200 cycles.
2. Clean press on key_in[0], held 60 cycles, then released:
   - key_press[0] is a single pulse 22 cycles after the fall;
   - key_level[0] = 1 until 22 cycles after the rise;
   - key_release[0] is a single pulse;
   - no key_long.
3. Bounce on key_in[1]: 5 pulses low for 8 cycles, high for 3 cycles, then steady low:
   - exactly one key_press[1], 22 cycles after the final fall;
   - no release in between.
4. Long press on key_in[2], held 300 cycles:
   - key_long[2] is exactly one pulse, 99 cycles after key_press[2];
   - it does not repeat;
   - release produces one key_release[2].
5. key_in[0] and key_in[3] fall on the same cycle: key_press[0] and key_press[3] pulse on the same cycle, each once.
6. rst_n is pulsed low for 3 cycles mid-hold, 10 cycles after key_press[1]:
   - outputs clear asynchronously;
   - no key_release is generated;
   - after reset, key_press[1] re-fires 22 cycles after reset release, because the key is still held.
